wb_ddr3_arbiter: RTL and testbench

Two-master to one-slave pipelined-Wishbone arbiter that shares the DDR3 controller's single Wishbone port between two requesters, e.g. the core's instruction and data paths. It sits between those requesters and the `ddr3_top` Wishbone slave port (32-bit address, 64-bit data, 8-bit select, stall/ack/err). It runs in the controller clock domain and provides:

- round-robin grant per bus cycle
- per-cycle outstanding-request tracking with a cap
- a no-response watchdog that aborts hung cycles

---
 rtl/wb_ddr3_arbiter.sv | 167 ++++++++++++++++
 tb/tb_wb_ddr3_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_ddr3_arbiter.sv
// rtl/wb_ddr3_arbiter.sv - two-master round-robin pipelined Wishbone arbiter in front of the DDR3 controller port
module wb_ddr3_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int SEL_W   = DATA_W / 8,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_wb_cyc,
    input  logic              m0_wb_stb,
    input  logic              m0_wb_we,
    input  logic [ADDR_W-1:0] m0_wb_addr,
    input  logic [DATA_W-1:0] m0_wb_data,
    input  logic [SEL_W-1:0]  m0_wb_sel,
    output logic              m0_wb_stall,
    output logic              m0_wb_ack,
    output logic              m0_wb_err,
    output logic [DATA_W-1:0] m0_wb_rdata,
    input  logic              m1_wb_cyc,
    input  logic              m1_wb_stb,
    input  logic              m1_wb_we,
    input  logic [ADDR_W-1:0] m1_wb_addr,
    input  logic [DATA_W-1:0] m1_wb_data,
    input  logic [SEL_W-1:0]  m1_wb_sel,
    output logic              m1_wb_stall,
    output logic              m1_wb_ack,
    output logic              m1_wb_err,
    output logic [DATA_W-1:0] m1_wb_rdata,
    output logic              s_wb_cyc,
    output logic              s_wb_stb,
    output logic              s_wb_we,
    output logic [ADDR_W-1:0] s_wb_addr,
    output logic [DATA_W-1:0] s_wb_data,
    output logic [SEL_W-1:0]  s_wb_sel,
    input  logic              s_wb_stall,
    input  logic              s_wb_ack,
    input  logic              s_wb_err,
    input  logic [DATA_W-1:0] s_wb_rdata
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [OUT_W-1:0] OUT_CAP  = OUT_W'(MAX_OUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ABORT} state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic               own_cyc, own_stb;
    logic               own_stall, own_ack, own_err;
    logic               cyc_c, stb_c, accept, resp, at_cap;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            out_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            out_q   <= out_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        out_d     = out_q;
        timer_d   = timer_q;
        cyc_c     = 1'b0;
        stb_c     = 1'b0;
        own_stall = 1'b1;
        own_ack   = 1'b0;
        own_err   = 1'b0;
        accept    = 1'b0;
        resp      = 1'b0;
        own_cyc   = owner_q ? m1_wb_cyc : m0_wb_cyc;
        own_stb   = owner_q ? m1_wb_stb : m0_wb_stb;
        at_cap    = (out_q == OUT_CAP);

        // Outputs are forced to their idle values while reset is held.
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    out_d   = '0;
                    timer_d = '0;
                    if (m0_wb_cyc || m1_wb_cyc) begin
                        owner_d = (m0_wb_cyc && m1_wb_cyc) ? !last_q : m1_wb_cyc;
                        last_d  = owner_d;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!own_cyc) begin
                        state_d = ST_IDLE;
                        out_d   = '0;
                        timer_d = '0;
                    end else begin
                        cyc_c     = 1'b1;
                        stb_c     = own_stb && !at_cap;
                        own_stall = s_wb_stall || at_cap;
                        own_ack   = s_wb_ack;
                        own_err   = s_wb_err;
                        accept    = stb_c && !s_wb_stall;
                        resp      = s_wb_ack || s_wb_err;
                        if (accept && !resp) begin
                            out_d = out_q + OUT_W'(1);
                        end else if (resp && !accept && out_q != '0) begin
                            out_d = out_q - OUT_W'(1);
                        end
                        // Activity counts as the first waited cycle so err lands TIMEOUT cycles after it.
                        if (out_d == '0) begin
                            timer_d = '0;
                        end else if (accept || resp) begin
                            timer_d = TMR_W'(1);
                        end else if (timer_q == TMR_LAST) begin
                            state_d = ST_ABORT;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q + TMR_W'(1);
                        end
                    end
                end
                ST_ABORT: begin
                    own_err = 1'b1;
                    state_d = ST_IDLE;
                    out_d   = '0;
                    timer_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    out_d   = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    assign s_wb_cyc    = cyc_c;
    assign s_wb_stb    = stb_c;
    assign s_wb_we     = owner_q ? m1_wb_we   : m0_wb_we;
    assign s_wb_addr   = owner_q ? m1_wb_addr : m0_wb_addr;
    assign s_wb_data   = owner_q ? m1_wb_data : m0_wb_data;
    assign s_wb_sel    = owner_q ? m1_wb_sel  : m0_wb_sel;

    assign m0_wb_stall = owner_q ? 1'b1 : own_stall;
    assign m0_wb_ack   = !owner_q && own_ack;
    assign m0_wb_err   = !owner_q && own_err;
    assign m0_wb_rdata = s_wb_rdata;
    assign m1_wb_stall = owner_q ? own_stall : 1'b1;
    assign m1_wb_ack   = owner_q && own_ack;
    assign m1_wb_err   = owner_q && own_err;
    assign m1_wb_rdata = s_wb_rdata;

endmodule

// File: tb/tb_wb_ddr3_arbiter.sv
// tb/tb_wb_ddr3_arbiter.sv - directed bench for the two-master Wishbone arbiter
module tb_wb_ddr3_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_wb_cyc, m0_wb_stb, m0_wb_we;
    logic [31:0] m0_wb_addr;
    logic [63:0] m0_wb_data;
    logic [7:0]  m0_wb_sel;
    logic        m0_wb_stall, m0_wb_ack, m0_wb_err;
    logic [63:0] m0_wb_rdata;
    logic        m1_wb_cyc, m1_wb_stb, m1_wb_we;
    logic [31:0] m1_wb_addr;
    logic [63:0] m1_wb_data;
    logic [7:0]  m1_wb_sel;
    logic        m1_wb_stall, m1_wb_ack, m1_wb_err;
    logic [63:0] m1_wb_rdata;
    logic        s_wb_cyc, s_wb_stb, s_wb_we;
    logic [31:0] s_wb_addr;
    logic [63:0] s_wb_data;
    logic [7:0]  s_wb_sel;
    logic        s_wb_stall, s_wb_ack, s_wb_err;
    logic [63:0] s_wb_rdata;

    int checks = 0;
    int errors = 0;

    wb_ddr3_arbiter #(
        .ADDR_W(32), .DATA_W(64), .SEL_W(8), .MAX_OUT(4), .TIMEOUT(16)
    ) dut (
        .clock(clock), .reset(reset),
        .m0_wb_cyc(m0_wb_cyc), .m0_wb_stb(m0_wb_stb), .m0_wb_we(m0_wb_we),
        .m0_wb_addr(m0_wb_addr), .m0_wb_data(m0_wb_data), .m0_wb_sel(m0_wb_sel),
        .m0_wb_stall(m0_wb_stall), .m0_wb_ack(m0_wb_ack), .m0_wb_err(m0_wb_err),
        .m0_wb_rdata(m0_wb_rdata),
        .m1_wb_cyc(m1_wb_cyc), .m1_wb_stb(m1_wb_stb), .m1_wb_we(m1_wb_we),
        .m1_wb_addr(m1_wb_addr), .m1_wb_data(m1_wb_data), .m1_wb_sel(m1_wb_sel),
        .m1_wb_stall(m1_wb_stall), .m1_wb_ack(m1_wb_ack), .m1_wb_err(m1_wb_err),
        .m1_wb_rdata(m1_wb_rdata),
        .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb), .s_wb_we(s_wb_we),
        .s_wb_addr(s_wb_addr), .s_wb_data(s_wb_data), .s_wb_sel(s_wb_sel),
        .s_wb_stall(s_wb_stall), .s_wb_ack(s_wb_ack), .s_wb_err(s_wb_err),
        .s_wb_rdata(s_wb_rdata)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        m0_wb_cyc  = 1'b0; m0_wb_stb = 1'b0; m0_wb_we = 1'b0;
        m1_wb_cyc  = 1'b0; m1_wb_stb = 1'b0; m1_wb_we = 1'b0;
        s_wb_ack   = 1'b0; s_wb_err  = 1'b0; s_wb_stall = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        m0_wb_addr = 32'h0; m0_wb_data = 64'h1111; m0_wb_sel = 8'hFF;
        m1_wb_addr = 32'h0; m1_wb_data = 64'h2222; m1_wb_sel = 8'h0F;
        s_wb_rdata = 64'h0;
        do_reset();

        // reset state
        #1;
        chk("rst_s_cyc", s_wb_cyc, 0);
        chk("rst_s_stb", s_wb_stb, 0);
        chk("rst_m0_stall", m0_wb_stall, 1);
        chk("rst_m1_stall", m1_wb_stall, 1);

        // single read by m0
        m0_wb_cyc = 1; m0_wb_stb = 1; m0_wb_addr = 32'h100;
        #1;
        chk("t1_idle_cyc", s_wb_cyc, 0);
        tick(); #1;
        chk("t1_grant_cyc", s_wb_cyc, 1);
        chk("t1_addr", s_wb_addr, 64'h100);
        chk("t1_stb", s_wb_stb, 1);
        chk("t1_m0_stall", m0_wb_stall, 0);
        tick(); m0_wb_stb = 0;
        tick();
        tick(); s_wb_ack = 1; s_wb_rdata = 64'hDEADBEEF_CAFEF00D; #1;
        chk("t1_m0_ack", m0_wb_ack, 1);
        chk("t1_m0_rdata", m0_wb_rdata, 64'hDEADBEEF_CAFEF00D);
        chk("t1_m1_ack", m1_wb_ack, 0);
        tick(); s_wb_ack = 0; m0_wb_cyc = 0; #1;
        chk("t1_drop_cyc", s_wb_cyc, 0);
        tick();

        // tie after reset, then alternation
        do_reset();
        m0_wb_cyc = 1; m0_wb_addr = 32'hA0;
        m1_wb_cyc = 1; m1_wb_addr = 32'hB0;
        tick(); #1;
        chk("t2_first_owner", s_wb_addr, 64'hA0);
        chk("t2_m1_stall", m1_wb_stall, 1);
        tick();
        tick(); m0_wb_cyc = 0; #1;
        chk("t2_release", s_wb_cyc, 0);
        tick(); m0_wb_cyc = 1; #1;
        chk("t2_gap", s_wb_cyc, 0);
        tick(); #1;
        chk("t2_second_owner", s_wb_addr, 64'hB0);
        chk("t2_m1_stall_own", m1_wb_stall, 0);
        chk("t2_m0_stall_other", m0_wb_stall, 1);
        tick(); m1_wb_cyc = 0;
        tick();
        tick(); #1;
        chk("t2_third_owner", s_wb_addr, 64'hA0);
        m0_wb_cyc = 0;
        tick();

        // outstanding cap
        m0_wb_cyc = 1; m0_wb_stb = 1; m0_wb_we = 0;
        tick(); #1;
        chk("t3_accept1", s_wb_stb, 1);
        tick();
        tick();
        tick(); #1;
        chk("t3_out3", 64'(dut.out_q), 3);
        chk("t3_accept4", s_wb_stb, 1);
        tick(); #1;
        chk("t3_cap_stall", m0_wb_stall, 1);
        chk("t3_cap_stb", s_wb_stb, 0);
        chk("t3_out4", 64'(dut.out_q), 4);
        tick(); s_wb_ack = 1; #1;
        chk("t3_ack_fwd", m0_wb_ack, 1);
        chk("t3_ack_stall", m0_wb_stall, 1);
        tick(); s_wb_ack = 0; #1;
        chk("t3_reopen_stb", s_wb_stb, 1);
        chk("t3_out_after_ack", 64'(dut.out_q), 3);
        tick(); #1;
        chk("t3_recap", m0_wb_stall, 1);

        // simultaneous accept+ack, and ack at zero
        m0_wb_stb = 0; s_wb_ack = 1;
        tick();
        tick(); m0_wb_stb = 1; #1;
        chk("t4_out2", 64'(dut.out_q), 2);
        tick(); m0_wb_stb = 0; #1;
        chk("t4_both_out2", 64'(dut.out_q), 2);
        tick();
        tick(); #1;
        chk("t4_out0", 64'(dut.out_q), 0);
        tick(); s_wb_ack = 0; #1;
        chk("t4_no_underflow", 64'(dut.out_q), 0);
        m0_wb_cyc = 0;
        tick();

        // watchdog with one write outstanding
        m0_wb_cyc = 1; m0_wb_stb = 1; m0_wb_we = 1; m0_wb_addr = 32'h200;
        tick(); #1;
        chk("t5_accept", s_wb_stb, 1);
        chk("t5_we", s_wb_we, 1);
        for (int k = 2; k <= 17; k++) begin
            tick(); m0_wb_stb = 0; #1;
            chk($sformatf("t5_err_c%0d", k), m0_wb_err, 64'(k == 17));
            chk($sformatf("t5_cyc_c%0d", k), s_wb_cyc, 64'(k != 17));
        end
        chk("t5_abort_stall", m0_wb_stall, 1);
        chk("t5_m1_err", m1_wb_err, 0);
        tick(); m0_wb_cyc = 0; s_wb_ack = 1; #1;
        chk("t5_late_ack", m0_wb_ack, 0);
        chk("t5_idle_cyc", s_wb_cyc, 0);
        tick(); s_wb_ack = 0;

        // reset mid-cycle with three outstanding
        m0_wb_cyc = 1; m0_wb_stb = 1; m0_wb_we = 0;
        tick();
        tick();
        tick();
        tick(); m0_wb_stb = 0; #1;
        chk("t6_out3", 64'(dut.out_q), 3);
        reset = 1; m0_wb_cyc = 0;
        tick(); reset = 0; s_wb_ack = 1; #1;
        chk("t6_s_cyc", s_wb_cyc, 0);
        chk("t6_m0_stall", m0_wb_stall, 1);
        chk("t6_m1_stall", m1_wb_stall, 1);
        chk("t6_out0", 64'(dut.out_q), 0);
        chk("t6_ack_drop", m0_wb_ack, 0);
        tick(); #1;
        chk("t6_ack_drop2", m0_wb_ack, 0);
        chk("t6_ack_drop_m1", m1_wb_ack, 0);
        s_wb_ack = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
